// File: rtl/bsg_mem_2r1w_sync_sched.sv
// Front-end scheduler for a 2-read/1-write sync-read RAM: valid/ready requests, fair same-address arbitration.
// Read responses arrive one cycle after accept and park in a one-entry hold per port while the consumer stalls.
module bsg_mem_2r1w_sync_sched
  #(parameter int width_p = 32
    ,parameter int els_p = 32
    ,parameter int read_write_same_addr_p = 0
    ,localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1)
  (input  logic                     clk_i
   ,input  logic                     reset_n_i

   ,input  logic                     w_v_i
   ,input  logic [addr_width_lp-1:0] w_addr_i
   ,input  logic [width_p-1:0]       w_data_i
   ,output logic                     w_ready_o

   ,input  logic                     r0_v_i
   ,input  logic [addr_width_lp-1:0] r0_addr_i
   ,output logic                     r0_ready_o
   ,output logic                     r0_v_o
   ,output logic [width_p-1:0]       r0_data_o
   ,input  logic                     r0_yumi_i

   ,input  logic                     r1_v_i
   ,input  logic [addr_width_lp-1:0] r1_addr_i
   ,output logic                     r1_ready_o
   ,output logic                     r1_v_o
   ,output logic [width_p-1:0]       r1_data_o
   ,input  logic                     r1_yumi_i

   ,output logic                     mem_w_v_o
   ,output logic [addr_width_lp-1:0] mem_w_addr_o
   ,output logic [width_p-1:0]       mem_w_data_o
   ,output logic                     mem_r0_v_o
   ,output logic [addr_width_lp-1:0] mem_r0_addr_o
   ,input  logic [width_p-1:0]       mem_r0_data_i
   ,output logic                     mem_r1_v_o
   ,output logic [addr_width_lp-1:0] mem_r1_addr_o
   ,input  logic [width_p-1:0]       mem_r1_data_i
   );

  localparam logic arb_en_lp = (read_write_same_addr_p == 0);

  logic [1:0] r_v, yumi, slot_free, elig, collide, r_ready, mem_r_v;
  logic [1:0] pend_r, held_r;
  logic       write_pri_r, w_ready;
  logic [addr_width_lp-1:0] r_addr   [2];
  logic [width_p-1:0]       mem_data [2];
  logic [width_p-1:0]       hold_r   [2];

  assign r_v       = {r1_v_i, r0_v_i};
  assign yumi      = {r1_yumi_i, r0_yumi_i};
  assign r_addr[0] = r0_addr_i;
  assign r_addr[1] = r1_addr_i;
  assign mem_data[0] = mem_r0_data_i;
  assign mem_data[1] = mem_r1_data_i;

  // A slot is free when nothing is parked and any pending response leaves this cycle.
  assign slot_free = ~held_r & ~(pend_r & ~yumi);
  assign elig      = r_v & slot_free;

  always_comb begin
    collide = '0;
    for (int k = 0; k < 2; k++)
      collide[k] = elig[k] & w_v_i & (r_addr[k] == w_addr_i) & arb_en_lp;
  end

  always_comb begin
    w_ready = 1'b1;
    r_ready = slot_free;
    if (|collide) begin
      if (write_pri_r) r_ready = slot_free & ~collide;
      else             w_ready = 1'b0;
    end
    if (!reset_n_i) begin
      w_ready = 1'b0;
      r_ready = '0;
    end
  end

  assign mem_r_v = r_v & r_ready;

  // Priority flips only when a collision was actually arbitrated.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      write_pri_r <= 1'b1;
      pend_r      <= '0;
      held_r      <= '0;
    end else begin
      if (|collide) write_pri_r <= ~write_pri_r;
      pend_r <= mem_r_v;
      for (int k = 0; k < 2; k++) begin
        if (pend_r[k] & ~yumi[k]) held_r[k] <= 1'b1;
        else if (yumi[k])         held_r[k] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 2; k++)
      if (pend_r[k] & ~yumi[k]) hold_r[k] <= mem_data[k];
  end

  assign w_ready_o     = w_ready;
  assign r0_ready_o    = r_ready[0];
  assign r1_ready_o    = r_ready[1];
  assign r0_v_o        = pend_r[0] | held_r[0];
  assign r1_v_o        = pend_r[1] | held_r[1];
  assign r0_data_o     = held_r[0] ? hold_r[0] : mem_r0_data_i;
  assign r1_data_o     = held_r[1] ? hold_r[1] : mem_r1_data_i;

  assign mem_w_v_o     = w_v_i & w_ready;
  assign mem_w_addr_o  = w_addr_i;
  assign mem_w_data_o  = w_data_i;
  assign mem_r0_v_o    = mem_r_v[0];
  assign mem_r0_addr_o = r0_addr_i;
  assign mem_r1_v_o    = mem_r_v[1];
  assign mem_r1_addr_o = r1_addr_i;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      if (mem_w_v_o) assert (int'(w_addr_i) < els_p) else $error("write address out of range");
      assert (!(r0_yumi_i && !r0_v_o)) else $error("r0 yumi without valid");
      assert (!(r1_yumi_i && !r1_v_o)) else $error("r1 yumi without valid");
      if (arb_en_lp) begin
        assert (!(mem_w_v_o && mem_r0_v_o && mem_w_addr_o == mem_r0_addr_o)) else $error("same-address r0/w");
        assert (!(mem_w_v_o && mem_r1_v_o && mem_w_addr_o == mem_r1_addr_o)) else $error("same-address r1/w");
      end
    end
  end
`endif

endmodule
